// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package instr_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted stream bytes MSB-first into a word; word_full marks the cycle
// the final byte of a word is being accepted.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          byte_en,
    input  logic [7:0]                    in_byte,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic                          word_full
);

    logic [BYTE_IDX_W-1:0]            idx;
    logic [8*(BYTES_PER_WORD-1)-1:0]  sh;

    // Only the leading bytes are stored; the last byte is taken straight from
    // the stream, so word is complete in the same cycle word_full is high.
    assign word      = {sh, in_byte};
    assign word_full = byte_en && (idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
            sh  <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (byte_en) begin
            idx <= idx + 1'b1;
            sh  <= {sh[8*(BYTES_PER_WORD-2)-1:0], in_byte};
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader: streams bytes into 32-bit words and writes them to the
// instruction memory from a base address, holding the CPU in reset meanwhile.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  wrap_err
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  asm_full;
    logic                  byte_en;
    logic                  asm_clear;

    assign byte_en   = in_valid && in_ready;
    assign asm_clear = (state == IDLE) && start;
    assign cpu_hold  = busy;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_en   (byte_en),
        .in_byte   (in_byte),
        .word      (asm_word),
        .word_full (asm_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrap_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        wrap_err <= 1'b0;
                        if (word_count != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= word_count;
                            in_ready    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (asm_full) begin
                        in_ready  <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= asm_word;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we      <= 1'b0;
                    addr_q      <= addr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                    if (addr_q == '1)
                        wrap_err <= 1'b1;
                    if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= LOAD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of load scenarios with random
// images, a byte-stream reference model, and hand sequences for reset/stall cases.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic [7:0]  in_byte;
    logic        in_ready, mem_we, busy, cpu_hold, done, wrap_err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .wrap_err   (wrap_err)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  img[$];
    logic [47:0] got[$];
    int unsigned acc;
    logic        pend_write, prev_we;
    int unsigned mode;
    logic        inject, injected;

    typedef struct {
        logic [15:0] base;
        logic [16:0] cnt;
        int unsigned mode;
        logic        inj;
        logic        exp_wrap;
    } vec_t;
    vec_t vecs[6];

    always @(negedge clk)
        if (mem_we === 1'b1) got.push_back({mem_addr, mem_wdata});

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle-level stream driver; expectations come from accepted-byte counting.
    task automatic drive(input int unsigned stop_acc, input int unsigned total);
        int unsigned cyc = 0;
        logic take;
        while (done !== 1'b1 && acc < stop_acc && cyc < 400) begin
            chk("busy", busy, 1'b1);
            chk("cpu_hold", cpu_hold, 1'b1);
            chk("mem_we_timing", mem_we, pend_write);
            chk("in_ready", in_ready, !pend_write);
            prev_we = mem_we;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (acc >= total) in_valid = 1'b0;
            in_byte = (in_valid && acc < img.size()) ? img[acc] : 8'($urandom);
            start = inject && !injected && acc >= 5;
            if (start) begin
                injected   = 1'b1;
                base_addr  = 16'h0BAD;
                word_count = 17'd9;
            end
            take = in_valid && in_ready;
            tick;
            start = 1'b0;
            if (take) acc++;
            pend_write = take && (acc % 4 == 0);
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] base, input logic [16:0] cnt,
                            input int unsigned m, input logic inj, input logic exp_wrap,
                            input logic keep_img);
        if (!keep_img) begin
            img.delete();
            for (int i = 0; i < 4 * int'(cnt); i++) img.push_back(8'($urandom));
        end
        got.delete();
        acc = 0; pend_write = 1'b0; prev_we = 1'b0;
        mode = m; inject = inj; injected = 1'b0;
        start = 1'b1; base_addr = base; word_count = cnt;
        tick;
        start = 1'b0; base_addr = 16'($urandom); word_count = 17'($urandom);
        chk("wrap_cleared", wrap_err, 1'b0);
        if (cnt == 0) begin
            chk("zero_done", done, 1'b1);
        end else begin
            chk("start_ready", in_ready, 1'b1);
            drive(32'hFFFF_FFFF, 4 * int'(cnt));
            chk("done_seen", done, 1'b1);
            chk("done_after_write", prev_we, 1'b1);
        end
        chk("done_busy", busy, 1'b0);
        chk("done_hold", cpu_hold, 1'b0);
        chk("done_we", mem_we, 1'b0);
        tick;
        chk("done_pulse", done, 1'b0);
        chk("idle_ready", in_ready, 1'b0);
        chk("nwrites", 48'(got.size()), 48'(cnt));
        for (int w = 0; w < int'(cnt) && w < got.size(); w++)
            chk("write", got[w], {base + 16'(w), img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});
        chk("wrap_err", wrap_err, exp_wrap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0010, 17'd2, 1, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 17'd0, 0, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 17'd2, 0, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 17'd3, 2, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFD, 17'd5, 2, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 17'd1, 0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        base_addr = 16'h0000; word_count = 17'd0;
        repeat (3) tick;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hold", cpu_hold, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wrap", wrap_err, 1'b0);
        reset = 1'b0;
        tick;

        // Known image at a fixed base
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        run_load(16'h0010, 17'd2, 0, 1'b0, 1'b0, 1'b1);
        if (got.size() == 2) begin
            chk("basic_w0", got[0], 48'h0010_DEADBEEF);
            chk("basic_w1", got[1], 48'h0011_01234567);
        end else begin
            chk("basic_count", 48'(got.size()), 48'd2);
        end

        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].inj, vecs[v].exp_wrap, 1'b0);
            tick;
        end

        // Reset after two bytes of the third word
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        got.delete();
        acc = 0; pend_write = 1'b0; prev_we = 1'b0; mode = 0; inject = 1'b0; injected = 1'b0;
        start = 1'b1; base_addr = 16'h0020; word_count = 17'd4;
        tick;
        start = 1'b0;
        drive(10, 16);
        chk("rst_mid_acc", 48'(acc), 48'd10);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst_mid_ready", in_ready, 1'b0);
        chk("rst_mid_we", mem_we, 1'b0);
        chk("rst_mid_addr", mem_addr, 16'h0000);
        chk("rst_mid_wdata", mem_wdata, 32'h0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_hold", cpu_hold, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_wrap", wrap_err, 1'b0);
        in_valid = 1'b1;
        repeat (6) tick;
        in_valid = 1'b0;
        chk("rst_mid_nwrites", 48'(got.size()), 48'd2);
        for (int w = 0; w < 2 && w < got.size(); w++)
            chk("rst_mid_write", got[w], {16'h0020 + 16'(w), img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]});

        run_load(16'h0000, 17'd2, 0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader that writes a program image into the instruction memory's write port before the processor starts fetching. It accepts a byte stream over a valid/ready handshake, packs each group of four bytes MSB-first into a 32-bit word, and writes consecutive words from a programmable base address. While a load is in progress it holds the fetch side in reset.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width; fixed at 4 bytes per word.
- ADDR_WIDTH, 16, word-address width of the instruction memory (2^16 words).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; latched on accepted start.
- word_count  input  ADDR_WIDTH+1  number of words to load (0..2^16); latched on accepted start.
- in_valid  input  1  in_byte is valid.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader accepts in_byte this cycle.
- mem_we  output  1  one-cycle write strobe to the instruction memory.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  DATA_WIDTH  packed word for the write.
- busy  output  1  load in progress (LOAD or WRITE state).
- cpu_hold  output  1  equals busy; holds the processor/PC in reset.
- done  output  1  one-cycle pulse when a load completes.
- wrap_err  output  1  sticky; set if the address wrapped past 2^ADDR_WIDTH-1; cleared by an accepted start.

## Operation
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start with word_count≠0 latches base_addr into addr_q and word_count into remaining_q, clears the byte index and wrap_err, then enters LOAD.
  - start with word_count=0 clears wrap_err and enters DONE directly; no write occurs.
- LOAD:
  - in_ready=1; a byte is accepted when in_valid && in_ready.
  - Accepted bytes shift into the assembly register MSB-first: the first byte becomes bits [31:24] and the fourth becomes [7:0].
  - A 2-bit byte index advances per accepted byte. On the 4th accepted byte the index returns to 0 and the next state is WRITE.
  - in_valid low simply stalls; there is no timeout.
- WRITE (one cycle):
  - in_ready=0, mem_we=1, mem_addr=addr_q, mem_wdata=assembly register.
  - At the end of the cycle, addr_q increments modulo 2^ADDR_WIDTH and remaining_q decrements.
  - If addr_q was all-ones, wrap_err is set.
  - Next state is DONE if remaining_q was 1, otherwise LOAD.
- DONE (one cycle): done=1, busy=0, then IDLE.
- start while not in IDLE is ignored. The latched base_addr and word_count are unaffected by input changes mid-load.
- in_byte and in_valid outside LOAD are ignored; in_ready is 0 there.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, wrap_err=0, state=IDLE, byte index=0.
- Reset asserted mid-load aborts immediately at the next edge. No further mem_we is issued, and the partially assembled word is discarded.
- start accepted at edge n → LOAD (in_ready=1) during cycle n+1.
- 4th byte accepted at edge m → mem_we=1 during cycle m+1 → LOAD again in cycle m+2.
- Maximum throughput is 4 bytes per 5 cycles.
- Final write in cycle k → done=1 in cycle k+1 → IDLE in cycle k+2. busy drops in the same cycle done rises.
- word_count=0: start at edge n → done=1 in cycle n+1.
- mem_addr and mem_wdata are registered and hold their last values outside WRITE. Only mem_we qualifies them.

## Structure
- Package instr_loader_pkg:
  - state enum {IDLE, LOAD, WRITE, DONE};
  - BYTES_PER_WORD=4;
  - BYTE_IDX_W=2.
- Sub-module word_assembler: shift register plus byte index.
  - Inputs: clk, reset, clear, byte_en, in_byte.
  - Outputs: word, word_full (the 4th byte is being accepted this cycle).
- The top level holds the FSM, the address/remaining counters and wrap_err.

## Test plan
- Basic load: base_addr=0x0010, word_count=2, bytes DE AD BE EF 01 23 45 67 with in_valid held high → writes 0xDEADBEEF@0x0010 and 0x01234567@0x0011, done pulses once, and busy/cpu_hold are high from start+1 through the last write.
- Stalls: same image with in_valid toggling 1,0,0,1 → identical writes. mem_we never asserts before the 4th accepted byte, and in_ready is 0 during each WRITE cycle.
- Zero length: word_count=0 → no mem_we, done=1 in the cycle after start.
- Wrap: base_addr=0xFFFF, word_count=2 → writes at 0xFFFF then 0x0000, wrap_err=1 after the second write. A subsequent start clears wrap_err.
- Reset mid-op: reset after 2 bytes of word 3 → all outputs at reset values next cycle and no write of word 3. A new start with base 0x0000 then loads correctly.
- start during busy: pulse start with different base_addr mid-load → ignored, and the original sequence completes unchanged.
